// File: rtl/axi4_wr2mem_if.sv
// AXI4 write-side bundle (AW/W/B channels) shared by the write-to-memory bridge and its masters.
// The slave modport is used by the bridge; the master modport by whatever drives it.
interface axi4_wr2mem_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 1
);
    logic [IW-1:0]   AWID;
    logic [AW-1:0]   AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi4_wr2mem.sv
// AXI4 write slave: accepts one burst at a time and turns every W beat into a single-word
// write on a simple synchronous memory port, then returns OKAY or SLVERR on B.
module axi4_wr2mem #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IW  = 1,
    parameter int MAW = AW - $clog2(DW/8)
) (
    input  logic            ACLK,
    input  logic            ARESET,
    axi4_wr2mem_if.slave    s_axi,
    output logic            mem_we,
    output logic [MAW-1:0]  mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be
);
    localparam int LSB = $clog2(DW/8);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;

    logic [IW-1:0]   r_id;
    logic [3:0]      r_len;
    logic [3:0]      r_cnt;
    logic [1:0]      r_burst;
    logic [MAW-1:0]  r_addr;
    logic            r_err;

    logic            r_mem_we;
    logic [MAW-1:0]  r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW/8-1:0] r_mem_be;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic            w_last_beat;
    logic            w_wlast_err;
    logic            w_aw_err;
    logic [MAW-1:0]  w_addr_inc;
    logic [MAW-1:0]  w_wrap_mask;
    logic [MAW-1:0]  w_wrap_addr;
    logic [MAW-1:0]  w_addr_next;

    assign w_aw_hs     = s_axi.AWVALID & r_awready;
    assign w_w_hs      = s_axi.WVALID & r_wready;
    assign w_b_hs      = s_axi.BREADY & r_bvalid;
    assign w_last_beat = (r_cnt == r_len);
    assign w_wlast_err = (s_axi.WLAST != w_last_beat);

    // WRAP is only legal for 2/4/8/16 beats; other lengths and reserved bursts are flagged.
    assign w_aw_err = (s_axi.AWSIZE != 3'(LSB))
                   || (s_axi.AWBURST == 2'b11)
                   || ((s_axi.AWBURST == 2'b10) && (s_axi.AWLEN != 4'd1) && (s_axi.AWLEN != 4'd3)
                       && (s_axi.AWLEN != 4'd7) && (s_axi.AWLEN != 4'd15));

    assign w_addr_inc  = r_addr + MAW'(1);
    assign w_wrap_mask = MAW'(r_len);

    // In a legal WRAP burst AWLEN is all-ones in the low bits, so it doubles as the window mask.
    genvar gi;
    generate
        for (gi = 0; gi < MAW; gi++) begin : g_wrap
            assign w_wrap_addr[gi] = w_wrap_mask[gi] ? w_addr_inc[gi] : r_addr[gi];
        end
    endgenerate

    always_comb begin
        w_addr_next = r_addr;
        case (r_burst)
            2'b01:   w_addr_next = w_addr_inc;
            2'b10:   w_addr_next = w_wrap_addr;
            default: w_addr_next = r_addr;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_awready <= (w_state_next == IDLE);
            r_wready  <= (w_state_next == DATA);
            r_bvalid  <= (w_state_next == RESP);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_aw_hs)                w_state_next = DATA;
            DATA:    if (w_w_hs && w_last_beat)  w_state_next = RESP;
            RESP:    if (w_b_hs)                 w_state_next = IDLE;
            default:                             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_id        <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_aw_hs) begin
                r_id    <= s_axi.AWID;
                r_len   <= s_axi.AWLEN;
                r_burst <= s_axi.AWBURST;
                r_addr  <= MAW'(s_axi.AWADDR >> LSB);
                r_cnt   <= '0;
                r_err   <= w_aw_err;
            end
            if (w_w_hs) begin
                // The write uses the error state from before this beat's WLAST check.
                r_mem_we    <= ~r_err;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= s_axi.WDATA;
                r_mem_be    <= s_axi.WSTRB;
                r_addr      <= w_addr_next;
                r_cnt       <= r_cnt + 4'd1;
                r_err       <= r_err | w_wlast_err;
            end
        end
    end

    always_comb begin
        s_axi.AWREADY = r_awready;
        s_axi.WREADY  = r_wready;
        s_axi.BVALID  = r_bvalid;
        s_axi.BID     = r_bvalid ? r_id : '0;
        s_axi.BRESP   = (r_bvalid && r_err) ? 2'b10 : 2'b00;
        mem_we        = r_mem_we;
        mem_addr      = r_mem_addr;
        mem_wdata     = r_mem_wdata;
        mem_be        = r_mem_be;
    end
endmodule

// File: tb/tb_axi4_wr2mem.sv
// Bench for axi4_wr2mem: directed vector table, hand-written reset sequence and
// randomized bursts checked against a word-level reference model.
module tb_axi4_wr2mem;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 1;
    localparam int MAW = 30;
    localparam int TMO = 200;
    localparam int NVEC = 11;
    localparam int NRND = 40;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi4_wr2mem_if #(.AW(AW), .DW(DW), .IW(IW)) bus ();

    logic            mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;

    axi4_wr2mem #(.AW(AW), .DW(DW), .IW(IW), .MAW(MAW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s_axi     (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    typedef struct packed {
        logic [MAW-1:0]  a;
        logic [DW-1:0]   d;
        logic [DW/8-1:0] be;
    } wr_t;

    typedef struct {
        logic [IW-1:0]       id;
        logic [AW-1:0]       addr;
        logic [3:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        int                  lastb;
        int                  bdelay;
        logic [1:0]          bresp;
        int                  nwr;
        logic [0:3][MAW-1:0] a;
    } vec_t;

    int checks = 0;
    int errors = 0;
    string tag = "";

    wr_t obs[$];
    wr_t exp_q[$];
    logic [DW-1:0]   bd_data [16];
    logic [DW/8-1:0] bd_strb [16];
    logic            bd_last [16];
    int              bd_gap  [16];
    vec_t tbl [NVEC];

    always @(negedge ACLK) begin
        if (mem_we === 1'b1) obs.push_back(wr_t'({mem_addr, mem_wdata, mem_be}));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Word-level model: addresses from the burst rules, writes skipped once the error flag is set.
    function automatic logic [1:0] model(input logic [AW-1:0] addr, input logic [3:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
        bit     err;
        longint base, win, start, wa;
        int     n;
        n = int'(len);
        exp_q.delete();
        err = (size != 3'd2) || (burst == 2'b11) ||
              (burst == 2'b10 && !(n == 1 || n == 3 || n == 7 || n == 15));
        base = longint'(addr) >> 2;
        for (int i = 0; i <= n; i++) begin
            case (burst)
                2'b01:   wa = (base + i) % (longint'(1) << 30);
                2'b10: begin
                    win   = n + 1;
                    start = base - (base % win);
                    wa    = start + ((base % win) + i) % win;
                end
                default: wa = base;
            endcase
            if (!err) exp_q.push_back(wr_t'({MAW'(wa), bd_data[i], bd_strb[i]}));
            if (bd_last[i] != (i == n)) err = 1'b1;
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic wait_ready(input string name, input int which);
        int n;
        n = 0;
        while (((which == 0) ? bus.AWREADY : bus.WREADY) !== 1'b1 && n < TMO) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout_%s: waited %0d cycles, limit %0d", tag, name, n, TMO);
        end
    endtask

    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit early_w,
                             input int bdelay, input logic [1:0] exp_bresp);
        obs.delete();
        @(negedge ACLK);
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWSIZE  = size;
        bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        if (early_w) begin
            bus.WDATA  = bd_data[0];
            bus.WSTRB  = bd_strb[0];
            bus.WLAST  = bd_last[0];
            bus.WVALID = 1'b1;
        end
        wait_ready("aw", 0);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        chk("wready_after_aw", bus.WREADY, 1);
        chk("awready_after_aw", bus.AWREADY, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (!(early_w && i == 0)) begin
                if (bd_gap[i] > 0) begin
                    bus.WVALID = 1'b0;
                    repeat (bd_gap[i]) @(negedge ACLK);
                end
                bus.WDATA  = bd_data[i];
                bus.WSTRB  = bd_strb[i];
                bus.WLAST  = bd_last[i];
                bus.WVALID = 1'b1;
            end
            wait_ready("w", 1);
            @(negedge ACLK);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        chk("bvalid_latency", bus.BVALID, 1);
        chk("wready_low_resp", bus.WREADY, 0);
        chk("bid", bus.BID, id);
        chk("bresp", bus.BRESP, exp_bresp);
        repeat (bdelay) begin
            @(negedge ACLK);
            chk("bvalid_hold", bus.BVALID, 1);
            chk("bid_hold", bus.BID, id);
            chk("bresp_hold", bus.BRESP, exp_bresp);
            chk("awready_resp", bus.AWREADY, 0);
            chk("wready_resp", bus.WREADY, 0);
        end
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        chk("bvalid_clear", bus.BVALID, 0);
        chk("awready_after_b", bus.AWREADY, 1);
        chk("nwrites", obs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
            chk("wr_addr", obs[k].a, exp_q[k].a);
            chk("wr_data", obs[k].d, exp_q[k].d);
            chk("wr_be", obs[k].be, exp_q[k].be);
        end
        $display("burst %s id=%0h addr=%h len=%0d size=%0d burst=%0d bresp=%b writes=%0d",
                 tag, id, addr, len, size, burst, exp_bresp, obs.size());
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_awready"}, bus.AWREADY, 0);
        chk({name, "_wready"}, bus.WREADY, 0);
        chk({name, "_bvalid"}, bus.BVALID, 0);
        chk({name, "_bid"}, bus.BID, 0);
        chk({name, "_bresp"}, bus.BRESP, 0);
        chk({name, "_mem_we"}, mem_we, 0);
        chk({name, "_mem_addr"}, mem_addr, 0);
        chk({name, "_mem_wdata"}, mem_wdata, 0);
        chk({name, "_mem_be"}, mem_be, 0);
    endtask

    task automatic table_data(input int lastb);
        for (int i = 0; i < 16; i++) begin
            bd_data[i] = DW'(32'hA0 + i);
            bd_strb[i] = 4'hF;
            bd_last[i] = (i == lastb);
            bd_gap[i]  = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] r_id;
        logic [AW-1:0] r_addr;
        logic [3:0]    r_len;
        logic [2:0]    r_size;
        logic [1:0]    r_burst;
        logic [1:0]    r_bresp;

        //        id    addr           len   size  burst  lastb bdly bresp  nwr  addresses
        tbl[0]  = '{1'b1, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 3,  0, 2'b00, 4, {30'h40, 30'h41, 30'h42, 30'h43}};
        tbl[1]  = '{1'b0, 32'h0000_0018, 4'd3, 3'd2, 2'b10, 3,  1, 2'b00, 4, {30'h06, 30'h07, 30'h04, 30'h05}};
        tbl[2]  = '{1'b1, 32'h0000_0000, 4'd1, 3'd1, 2'b01, 1,  0, 2'b10, 0, {30'h0, 30'h0, 30'h0, 30'h0}};
        tbl[3]  = '{1'b0, 32'h0000_0200, 4'd2, 3'd2, 2'b01, 1,  0, 2'b10, 2, {30'h80, 30'h81, 30'h0, 30'h0}};
        tbl[4]  = '{1'b1, 32'h0000_0300, 4'd0, 3'd2, 2'b01, 0,  5, 2'b00, 1, {30'hC0, 30'h0, 30'h0, 30'h0}};
        tbl[5]  = '{1'b0, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 3,  0, 2'b00, 4, {30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1}};
        tbl[6]  = '{1'b1, 32'h0000_0044, 4'd2, 3'd2, 2'b00, 2,  0, 2'b00, 3, {30'h11, 30'h11, 30'h11, 30'h0}};
        tbl[7]  = '{1'b0, 32'h0000_0044, 4'd1, 3'd2, 2'b10, 1,  0, 2'b00, 2, {30'h11, 30'h10, 30'h0, 30'h0}};
        tbl[8]  = '{1'b1, 32'h0000_0010, 4'd2, 3'd2, 2'b10, 2,  0, 2'b10, 0, {30'h0, 30'h0, 30'h0, 30'h0}};
        tbl[9]  = '{1'b0, 32'h0000_0010, 4'd0, 3'd2, 2'b11, 0,  0, 2'b10, 0, {30'h0, 30'h0, 30'h0, 30'h0}};
        tbl[10] = '{1'b1, 32'h0000_0020, 4'd1, 3'd2, 2'b01, 99, 0, 2'b10, 2, {30'h08, 30'h09, 30'h0, 30'h0}};

        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;

        tag = "reset";
        repeat (3) @(negedge ACLK);
        check_all_zero("in_reset");
        ARESET = 1'b0;
        #1;
        chk("awready_before_edge", bus.AWREADY, 0);
        @(posedge ACLK);
        #1;
        chk("awready_first_edge", bus.AWREADY, 1);

        for (int t = 0; t < NVEC; t++) begin
            $sformat(tag, "vec%0d", t);
            table_data(tbl[t].lastb);
            exp_q.delete();
            for (int k = 0; k < tbl[t].nwr; k++)
                exp_q.push_back(wr_t'({tbl[t].a[k], DW'(32'hA0 + k), 4'hF}));
            run_burst(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst,
                      1'b0, tbl[t].bdelay, tbl[t].bresp);
        end

        // Reset pulsed after the second beat of a 4-beat INCR burst.
        tag = "midreset";
        table_data(3);
        @(negedge ACLK);
        bus.AWID = 1'b1; bus.AWADDR = 32'h400; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        wait_ready("aw", 0);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.WDATA = bd_data[i]; bus.WSTRB = bd_strb[i]; bus.WLAST = bd_last[i]; bus.WVALID = 1'b1;
            wait_ready("w", 1);
            @(negedge ACLK);
        end
        chk("we_before_rst", mem_we, 1);
        chk("addr_before_rst", mem_addr, 30'h101);
        #1 ARESET = 1'b1;
        #1;
        check_all_zero("async");
        bus.WVALID = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            chk("bvalid_in_rst", bus.BVALID, 0);
        end
        ARESET = 1'b0;
        #1;
        chk("awready_rel", bus.AWREADY, 0);
        @(negedge ACLK);
        chk("awready_after_rel", bus.AWREADY, 1);
        chk("bvalid_after_rel", bus.BVALID, 0);
        tag = "fresh";
        table_data(tbl[0].lastb);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(wr_t'({tbl[0].a[k], DW'(32'hA0 + k), 4'hF}));
        run_burst(1'b0, tbl[0].addr, tbl[0].len, tbl[0].size, tbl[0].burst, 1'b0, 0, 2'b00);

        for (int r = 0; r < NRND; r++) begin
            $sformat(tag, "rnd%0d", r);
            r_id    = IW'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_len   = 4'($urandom_range(0, 15));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            r_burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (r_burst == 2'b10 && $urandom_range(0, 3) != 0)
                r_len = 4'((2 << $urandom_range(0, 3)) - 1);
            for (int i = 0; i < 16; i++) begin
                bd_data[i] = $urandom;
                bd_strb[i] = 4'($urandom_range(0, 15));
                bd_last[i] = (i == int'(r_len)) ^ ($urandom_range(0, 15) == 0);
                bd_gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            r_bresp = model(r_addr, r_len, r_size, r_burst);
            run_burst(r_id, r_addr, r_len, r_size, r_burst, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), r_bresp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
